// File: rtl/music_pkg.sv
// Shared definitions for the note playback path: note-word layout, FSM states, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package music_pkg;

    // Default system clock, used to derive the duration tick.
    localparam int DEF_CLK_HZ = 50_000_000;

    // Note word layout: [11:8] pitch index, [7:5] band, [4:0] duration units.
    localparam int WORD_W    = 12;
    localparam int PITCH_MSB = 11;
    localparam int PITCH_LSB = 8;
    localparam int BAND_MSB  = 7;
    localparam int BAND_LSB  = 5;
    localparam int DUR_MSB   = 4;
    localparam int DUR_LSB   = 0;

    // A zero duration marks the end of the song.
    localparam logic [DUR_MSB-DUR_LSB:0] DUR_END = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SOUND,
        ST_GAP,
        ST_PAUSED
    } seq_state_t;

    // Pitch 0 is a rest, so it has no gate bit.
    function automatic logic [15:0] pitch_onehot(input logic [PITCH_MSB-PITCH_LSB:0] pitch);
        return (pitch == '0) ? 16'h0000 : (16'h0001 << pitch);
    endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter timing fetch latency, note sound time and articulation gap.
// Latency: a load of N gives expire on the N-th enabled cycle after the load edge.
// Backpressure: en low freezes the count; clr and load take priority over counting.
module note_timer
    import music_pkg::*;
#(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Count down the remaining cycles of the current phase; holds at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - CNT_W'(1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The last enabled cycle of the phase is the one where the count sits at zero.
    assign expire = en && (cnt == '0);

endmodule

// File: rtl/note_sequencer.sv
// Note ROM playback controller: fetches note words, gates the tone, times notes and gaps.
// Latency: note gate rises ROM_LAT+2 cycles after the start pulse; note period is dur*TICK_DIV.
// Backpressure: none; play_pause freezes all timing in PAUSED, stop aborts to IDLE.
module note_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int TICK_DIV = CLK_HZ / 16,
    parameter int GAP_CYC  = 250000,
    parameter int ROM_LAT  = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] track_base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [15:0]       note_onehot,
    output logic [2:0]        band,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    // Wide enough for the longest note, 31 ticks, without overflow.
    localparam int CNT_W = $clog2(31 * TICK_DIV + 1);

    // FETCH holds for ROM_LAT cycles of latency plus the decode cycle.
    localparam logic [CNT_W-1:0] FETCH_LEN = CNT_W'(ROM_LAT + 1);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_CYC);

    seq_state_t state_q, state_d;
    seq_state_t saved_q, saved_d;
    seq_state_t exit_src;
    logic       pend_q, pend_d;
    logic       do_exit;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       onehot_q, onehot_d;
    logic [2:0]        band_q, band_d;
    logic              done_q, done_d;

    logic             tmr_clr;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_exp;

    // Note word fields.
    logic [PITCH_MSB-PITCH_LSB:0] w_pitch;
    logic [BAND_MSB-BAND_LSB:0]   w_band;
    logic [DUR_MSB-DUR_LSB:0]     w_dur;
    logic [CNT_W-1:0]             sound_len;

    assign w_pitch = rom_data[PITCH_MSB:PITCH_LSB];
    assign w_band  = rom_data[BAND_MSB:BAND_LSB];
    assign w_dur   = rom_data[DUR_MSB:DUR_LSB];

    // Sound time leaves room for the gap so the note period is exactly dur ticks.
    assign sound_len = CNT_W'(w_dur) * CNT_W'(TICK_DIV) - GAP_LEN;

    // The timer only runs in the active phases, so PAUSED freezes it.
    assign tmr_en = (state_q == ST_FETCH) || (state_q == ST_SOUND) || (state_q == ST_GAP);

    note_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_exp)
    );

    // Next-state, decode and datapath updates; stop overrides everything else.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        pend_d   = pend_q;
        base_d   = base_q;
        addr_d   = addr_q;
        onehot_d = onehot_q;
        band_d   = band_q;
        done_d   = 1'b0;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        do_exit  = 1'b0;
        exit_src = state_q;

        unique case (state_q)
            ST_IDLE: begin
                if (play_pause) begin
                    base_d   = track_base;
                    addr_d   = track_base;
                    state_d  = ST_FETCH;
                    tmr_load = 1'b1;
                    tmr_val  = FETCH_LEN;
                end
            end
            ST_FETCH, ST_SOUND, ST_GAP: begin
                if (play_pause) begin
                    // A phase ending in the pause cycle is remembered and taken on resume.
                    saved_d = state_q;
                    pend_d  = (state_q != ST_FETCH) && tmr_exp;
                    state_d = ST_PAUSED;
                end else if (tmr_exp) begin
                    do_exit = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (play_pause) begin
                    pend_d = 1'b0;
                    if (pend_q) begin
                        exit_src = saved_q;
                        do_exit  = 1'b1;
                    end else begin
                        state_d = saved_q;
                        // The ROM word is sampled again, so latency restarts.
                        if (saved_q == ST_FETCH) begin
                            tmr_load = 1'b1;
                            tmr_val  = FETCH_LEN;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_exit) begin
            case (exit_src)
                ST_SOUND: begin
                    // Prefetch the next word during the gap.
                    state_d  = ST_GAP;
                    addr_d   = addr_q + ADDR_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LEN;
                end
                ST_FETCH, ST_GAP: begin
                    if (w_dur == DUR_END) begin
                        if (loop_en) begin
                            addr_d   = base_q;
                            state_d  = ST_FETCH;
                            tmr_load = 1'b1;
                            tmr_val  = FETCH_LEN;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        band_d   = w_band;
                        onehot_d = pitch_onehot(w_pitch);
                        state_d  = ST_SOUND;
                        tmr_load = 1'b1;
                        tmr_val  = sound_len;
                    end
                end
                default: begin
                end
            endcase
        end

        if (stop) begin
            state_d  = ST_IDLE;
            saved_d  = ST_IDLE;
            pend_d   = 1'b0;
            base_d   = '0;
            addr_d   = '0;
            onehot_d = '0;
            band_d   = '0;
            done_d   = 1'b0;
            tmr_clr  = 1'b1;
            tmr_load = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            saved_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            base_q   <= '0;
            addr_q   <= '0;
            onehot_q <= '0;
            band_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            pend_q   <= pend_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            onehot_q <= onehot_d;
            band_q   <= band_d;
            done_q   <= done_d;
        end
    end

    // The held pitch is only driven out while sounding; gap and pause gate it off.
    assign note_onehot = (state_q == ST_SOUND) ? onehot_q : 16'h0000;
    assign note_valid  = (state_q == ST_SOUND) && (onehot_q != 16'h0000);
    assign band        = band_q;
    assign rom_addr    = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 2;
    localparam int LAT  = 1;
    localparam int AW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          play_pause = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] track_base = '0;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data = '0;
    logic [15:0]   note_onehot;
    logic [2:0]    band;
    logic          note_valid;
    logic          busy;
    logic          done;

    logic [11:0] rom [0:65535];

    // Song under test: song[0..nnotes-1] are notes, song[nnotes] is the end word.
    logic [11:0] song [0:7];
    int          nnotes;

    // Expected outputs indexed by logical cycle after the start pulse.
    logic        e_nv   [0:511];
    logic [15:0] e_oh   [0:511];
    logic [2:0]  e_band [0:511];
    logic        e_busy [0:511];
    logic        e_done [0:511];
    logic [15:0] e_addr [0:511];
    int          e_len;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    note_sequencer #(
        .CLK_HZ   (64),
        .TICK_DIV (TICK),
        .GAP_CYC  (GAP),
        .ROM_LAT  (LAT),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .play_pause  (play_pause),
        .stop        (stop),
        .loop_en     (loop_en),
        .track_base  (track_base),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_onehot (note_onehot),
        .band        (band),
        .note_valid  (note_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Song timeline: fetch for 2 cycles, then each note sounds dur*TICK-GAP cycles
    // and is silent for GAP cycles; the address steps at each gap start.
    task automatic build_model(input logic [15:0] base);
        int          s;
        int          dur;
        int          pitch;
        logic [15:0] a;
        for (int i = 0; i < 512; i++) begin
            e_nv[i] = 1'b0; e_oh[i] = '0; e_band[i] = '0;
            e_busy[i] = 1'b0; e_done[i] = 1'b0; e_addr[i] = base;
        end
        e_addr[0] = '0;
        e_busy[1] = 1'b1;
        e_busy[2] = 1'b1;
        s = 3;
        a = base;
        e_len = 0;
        for (int k = 0; k <= nnotes; k++) begin
            dur   = int'(song[k][4:0]);
            pitch = int'(song[k][11:8]);
            rom[a] = song[k];
            if (dur == 0) begin
                e_done[s] = 1'b1;
                e_len = s;
                for (int i = s; i < 512; i++) e_addr[i] = a;
                break;
            end
            for (int i = 0; i < dur * TICK; i++) begin
                e_busy[s+i] = 1'b1;
                if (i < dur * TICK - GAP) begin
                    e_addr[s+i] = a;
                    e_nv[s+i]   = (pitch != 0);
                    e_oh[s+i]   = (pitch != 0) ? (16'd1 << pitch) : 16'd0;
                    e_band[s+i] = song[k][7:5];
                end else begin
                    e_addr[s+i] = a + 16'd1;
                end
            end
            a = a + 16'd1;
            s = s + dur * TICK;
        end
    endtask

    // Plays the current song from base; an optional pause at cycle p lasting hold
    // cycles shifts the whole timeline by hold (p < 0 picks a random pause point).
    task automatic run_trial(input logic [15:0] base, input bit pz, input int p_in,
                             input int hold, input string tag);
        int L;
        int p;
        build_model(base);
        p = p_in;
        if (pz && p < 0) p = $urandom_range(3, e_len - 1);
        track_base = base;
        loop_en = 1'b0;
        for (int c = 0; c <= e_len + 2 + (pz ? hold : 0); c++) begin
            play_pause = (c == 0) || (pz && ((c == p) || (c == p + hold)));
            @(negedge clk);
            if (pz && c > p && c <= p + hold) begin
                chk({tag, ":pz_nv"}, note_valid, 0);
                chk({tag, ":pz_oh"}, note_onehot, 0);
                chk({tag, ":pz_busy"}, busy, 1);
                chk({tag, ":pz_addr"}, rom_addr, e_addr[p]);
            end else begin
                L = (pz && c > p) ? c - hold : c;
                chk({tag, ":nv"}, note_valid, e_nv[L]);
                chk({tag, ":oh"}, note_onehot, e_oh[L]);
                chk({tag, ":busy"}, busy, e_busy[L]);
                chk({tag, ":done"}, done, e_done[L]);
                chk({tag, ":addr"}, rom_addr, e_addr[L]);
                if (e_nv[L]) chk({tag, ":band"}, band, e_band[L]);
            end
            @(posedge clk); #1;
        end
        play_pause = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":nv"}, note_valid, 0);
        chk({tag, ":oh"}, note_onehot, 0);
        chk({tag, ":addr"}, rom_addr, 0);
        chk({tag, ":band"}, band, 0);
        chk({tag, ":done"}, done, 0);
    endtask

    task automatic loop_test();
        int m;
        rom[16'h0010] = 12'h342;
        rom[16'h0011] = 12'h000;
        track_base = 16'h0010;
        loop_en = 1'b1;
        for (int c = 0; c < 41; c++) begin
            play_pause = (c == 0);
            @(negedge clk);
            if (c > 0) begin
                m = (c - 1) % 10;
                chk("loop:addr", rom_addr, (m >= 8) ? 16'h0011 : 16'h0010);
                chk("loop:nv", note_valid, (m >= 2 && m <= 7) ? 1 : 0);
                chk("loop:busy", busy, 1);
                chk("loop:done", done, 0);
            end
            @(posedge clk); #1;
        end
        play_pause = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        loop_en = 1'b0;
        @(negedge clk);
        check_cleared("loop_stop");
        @(posedge clk); #1;
    endtask

    // Start a note and advance to cycle 5, which is inside its sounding phase.
    task automatic start_to_sound(input logic [15:0] base);
        rom[base] = 12'h342;
        rom[base + 16'd1] = 12'h000;
        track_base = base;
        play_pause = 1'b1;
        @(posedge clk); #1;
        play_pause = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] base;
        for (int i = 0; i < 65536; i++) rom[i] = 12'h000;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        nnotes = 1; song[0] = 12'h342; song[1] = 12'h000;
        run_trial(16'h0000, 1'b0, 0, 0, "note");

        nnotes = 2; song[0] = 12'h041; song[1] = 12'h542; song[2] = 12'h000;
        run_trial(16'h0000, 1'b0, 0, 0, "rest");

        nnotes = 1; song[0] = 12'h342; song[1] = 12'h000;
        run_trial(16'h0000, 1'b1, 4, 10, "pause");
        run_trial(16'hFFFF, 1'b0, 0, 0, "wrap");
        run_trial(16'h0000, 1'b1, 8, 3, "pause_end");

        loop_test();

        // stop and play_pause together mid-note: stop wins.
        start_to_sound(16'h0020);
        @(negedge clk);
        chk("stop:pre_nv", note_valid, 1);
        @(posedge clk); #1;
        stop = 1'b1;
        play_pause = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        play_pause = 1'b0;
        @(negedge clk);
        check_cleared("stop");
        @(posedge clk); #1;
        nnotes = 1; song[0] = 12'h342; song[1] = 12'h000;
        run_trial(16'h0020, 1'b0, 0, 0, "restart");

        // Asynchronous reset in the middle of a note.
        start_to_sound(16'h0030);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("arst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 40; t++) begin
            nnotes = $urandom_range(1, 4);
            for (int k = 0; k < nnotes; k++) begin
                song[k] = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                           5'($urandom_range(1, 5))};
            end
            song[nnotes] = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 5'd0};
            base = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            run_trial(base, 1'($urandom_range(0, 1)), -1, $urandom_range(1, 12), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Playback controller that sequences the note ROM. It issues ROM addresses, decodes each 12-bit note word and times its duration.
- Drives a one-hot pitch, a band (octave) and a gate to the tone generator, and inserts a short articulation gap between notes.
- Handles play/pause/stop, track start address, end-of-song marker and optional looping.
- Sits between the user-control debouncers and the note ROM / tone generator.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_DIV, CLK_HZ/16, clock cycles per duration unit.
- GAP_CYC, 250000, silent cycles at the end of each note. Legal range: ROM_LAT+1 <= GAP_CYC < TICK_DIV.
- ROM_LAT, 1, ROM read latency in cycles (address to data).
- ADDR_W, 16, ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- play_pause  in  1  single-cycle pulse; starts from idle, otherwise toggles pause.
- stop  in  1  single-cycle pulse; abort to idle.
- loop_en  in  1  replay the track on reaching the end marker.
- track_base  in  ADDR_W  first word address; latched on start.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  12  note word: [11:8] pitch index, [7:5] band, [4:0] duration units.
- note_onehot  out  16  bit[pitch] set while sounding; 0 otherwise.
- band  out  3  registered band of the current note.
- note_valid  out  1  tone gate.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset: state IDLE; rom_addr, note_onehot, band, note_valid, busy, done, all counters and the latched base are 0.
- States: IDLE, FETCH, SOUND, GAP, PAUSED.
- IDLE + play_pause:
  - Latch track_base into base_r; rom_addr <= track_base; go to FETCH.
  - FETCH waits ROM_LAT cycles, then decodes on the next edge.
  - note_valid rises ROM_LAT+2 cycles after the pulse cycle.
- Decode (FETCH exit or GAP exit):
  - dur == 0: end marker.
    - loop_en=1: rom_addr <= base_r; go to FETCH.
    - loop_en=0: pulse done for 1 cycle; go to IDLE.
  - dur != 0:
    - Register band and note_onehot = (pitch==0) ? 0 : 1<<pitch.
    - note_valid = (pitch != 0); pitch 0 is a rest with normal timing.
    - Go to SOUND.
- SOUND: lasts exactly dur*TICK_DIV - GAP_CYC cycles, then GAP.
  - Counter is wide enough for 31*TICK_DIV with no overflow.
- GAP: lasts GAP_CYC cycles.
  - Gate is off: note_valid=0, note_onehot=0; band holds.
  - rom_addr <= rom_addr+1 on GAP entry (prefetch), so the next word is ready by GAP exit.
  - Note-to-note period is exactly dur*TICK_DIV cycles.
- Address wrap: rom_addr wraps 2^ADDR_W-1 -> 0 silently.
- Pause:
  - play_pause in FETCH/SOUND/GAP saves the state and goes to PAUSED.
  - In PAUSED, counters and rom_addr are frozen and note_valid=0; note_onehot is held but gated.
  - A second pulse restores the saved state. Remaining time is preserved, and the gate re-asserts only if the saved state was SOUND with a non-rest note.
  - Pause in FETCH: the ROM word is re-sampled after resume, so FETCH restarts its latency count.
- Stop (any state): go to IDLE next edge; outputs and counters cleared as at reset; done not pulsed.
- Simultaneous events:
  - stop beats play_pause.
  - play_pause in the same cycle a note ends: pause wins, and the transition is deferred until resume.
- Mid-operation reset: immediate asynchronous clear to the reset values.
- Input changes: track_base changes after start are ignored. loop_en is sampled only at the end marker.

Decomposition:
- Shared package music_pkg:
  - Note-word field positions (PITCH_MSB/LSB, BAND_MSB/LSB, DUR_MSB/LSB).
  - DUR_END = 0.
  - State enum type.
  - Default CLK_HZ.
- Natural sub-module: note_timer. Loadable down-counter with load value dur*TICK_DIV-GAP_CYC or GAP_CYC, freeze enable and an expire pulse.
- The FSM and decode stay in note_sequencer.

Test Plan (TICK_DIV=4, GAP_CYC=2, ROM_LAT=1, ROM modelled with 1-cycle latency):
- ROM[0]=0x342, ROM[1]=0x000, loop_en=0, play_pause at cycle 0:
  - note_valid=1, note_onehot=0x0008, band=2 from cycle 3 for 6 cycles, then 2 gap cycles.
  - done pulses once; busy falls; rom_addr sequence 0,1.
- ROM[0]=0x041 (pitch 0, dur 1), ROM[1]=0x542: rest keeps note_valid=0 for 4 cycles; then note_onehot=0x0020 for 6 cycles; period checks are exact.
- Pause 2 cycles into SOUND of 0x342, hold 10 cycles, resume: note_valid low while paused, then high for exactly 4 more cycles; total gated time is 6.
- loop_en=1, track_base=0x0010, ROM[0x10]=0x342, ROM[0x11]=0x000: rom_addr cycles 0x10,0x11,0x10...; done never pulses.
- stop and play_pause asserted in the same cycle during SOUND: next cycle is IDLE, all outputs 0; a later play_pause restarts at track_base.
- track_base=0xFFFF, ROM[0xFFFF]=0x342, ROM[0]=0x000: after the note, rom_addr wraps to 0x0000 and done pulses. Reset asserted mid-SOUND clears all outputs asynchronously.
